sp1_ram: RTL and testbench

- Single-port synchronous RAM, 64 words x 32 bits, used as the stgpm-mk1 local data/scratch store.
- One shared address bus, one write data bus, one registered read data bus.
- Access is qualified by chip-select; a write-enable selects write or read.
- Read data appears one clock after the read request.

---
 rtl/sp1_ram.sv | 62 ++++++
 tb/tb_sp1_ram.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sp1_ram.sv
// sp1_ram: 64x32 single-port synchronous RAM with registered read data.
// Synchronous active-low reset clears every word and the output register.
module sp1_ram #(
    parameter int DW    = 32,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_d;
    logic          wr_en;
    logic          rd_en;

    // cs is tested first so X on we/adr/din while idle cannot leak into state
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (cs == 1'b1) begin
            wr_en = (we == 1'b1);
            rd_en = (we == 1'b0);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[adr] = din;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (rd_en) begin
            dout_d = mem_q[adr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sp1_ram.sv
// tb_sp1_ram: directed checks of reset, write/read, hold, deselect,
// read-after-write, back-to-back reads and reset priority.
module tb_sp1_ram;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        we;
    logic [5:0]  adr;
    logic [31:0] din;
    logic [31:0] dout;

    int checks;
    int errors;

    sp1_ram #(.DW(32), .AW(6), .DEPTH(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .adr  (adr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (dout === exp) else begin
            errors++;
            $error("FAIL %s: dout=%h expected=%h", tag, dout, exp);
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d);
        cs  = 1'b1;
        we  = 1'b1;
        adr = a;
        din = d;
        tick();
    endtask

    task automatic do_read(input logic [5:0] a);
        cs  = 1'b1;
        we  = 1'b0;
        adr = a;
        din = 'x;
        tick();
    endtask

    task automatic go_idle();
        cs  = 1'b0;
        we  = 1'bx;
        adr = 'x;
        din = 'x;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        go_idle();

        // 1. reset clears memory
        tick();
        tick();
        tick();
        check("reset_dout", 32'h0000_0000);
        rst = 1'b1;
        do_read(6'h00);
        check("rst_rd_00", 32'h0000_0000);
        do_read(6'h15);
        check("rst_rd_15", 32'h0000_0000);
        do_read(6'h3f);
        check("rst_rd_3f", 32'h0000_0000);

        // 2. basic write/read
        do_write(6'h00, 32'h1234_5678);
        check("wr_hold_a", 32'h0000_0000);
        do_write(6'h3f, 32'hdead_beef);
        do_write(6'h2a, 32'ha5a5_a5a5);
        check("wr_hold_b", 32'h0000_0000);
        do_read(6'h3f);
        check("rd_3f", 32'hdead_beef);
        do_read(6'h00);
        check("rd_00", 32'h1234_5678);
        do_read(6'h2a);
        check("rd_2a", 32'ha5a5_a5a5);

        // 3. hold while idle with X inputs and across a write
        do_read(6'h3f);
        check("hold_rd_3f", 32'hdead_beef);
        go_idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_hold", 32'hdead_beef);
        end
        do_write(6'h01, 32'hffff_ffff);
        check("wr_hold_c", 32'hdead_beef);
        do_read(6'h01);
        check("rd_01", 32'hffff_ffff);

        // 4. deselected write ignored
        cs  = 1'b0;
        we  = 1'b1;
        adr = 6'h00;
        din = 32'hcafe_f00d;
        tick();
        check("desel_hold", 32'hffff_ffff);
        do_read(6'h00);
        check("desel_rd_00", 32'h1234_5678);

        // 5. read-after-write and back-to-back reads
        do_write(6'h10, 32'h0000_0001);
        do_read(6'h10);
        check("raw_10", 32'h0000_0001);
        do_read(6'h10);
        check("b2b_10", 32'h0000_0001);
        do_read(6'h3f);
        check("b2b_3f", 32'hdead_beef);

        // 6. reset takes priority over a read
        rst = 1'b0;
        do_read(6'h3f);
        check("rst_prio", 32'h0000_0000);
        rst = 1'b1;
        do_read(6'h3f);
        check("post_rst_3f", 32'h0000_0000);
        do_read(6'h00);
        check("post_rst_00", 32'h0000_0000);
        do_read(6'h2a);
        check("post_rst_2a", 32'h0000_0000);
        go_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
